sample_frame_streamer: RTL and testbench
========================================

# sample_frame_streamer

Parametrised multichannel sample source and UART framer. On every sample tick it snapshots one sample per channel, either generated internally (sawtooth, constant or channel-index pattern) or taken from an external bus. It then streams a framed byte sequence (sync, frame count, samples MSB-first) into the existing `uart_tx` byte interface. It replaces the fixed single-channel 8-bit sawtooth feeder in the serial-mic top level, and adds overrun accounting and back-pressure from `uart_busy`.

## Interface
- `CHANNELS`, 2: number of channels per frame, 1..8.
- `SAMPLE_WIDTH`, 16: bits per sample; must be 8, 16 or 24. `BYTES = SAMPLE_WIDTH/8`.
- `TICKS_PER_SAMPLE`, 250: clock cycles per sample tick, at least 2.
- `WAVE_PERIOD`, 100: sawtooth period in samples, at least 1.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

Ports:
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, the tick counter holds at 0 and no new frames start. A frame already in flight completes.
- `mode`  in  2  pattern select, sampled on the tick: 0 sawtooth, 1 external, 2 constant, 3 channel index.
- `ext_samples`  in  CHANNELS*SAMPLE_WIDTH  external samples; channel c occupies bits [c*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- `uart_busy`  in  1  from `uart_tx`; asserted the cycle after a byte is accepted.
- `data`  out  8  byte to `uart_tx`.
- `data_valid`  out  1  one-cycle strobe; `data` is valid only in that cycle.
- `frame_active`  out  1  high from snapshot until the last byte of the frame is accepted.
- `overrun_count`  out  8  number of ticks dropped because a frame was in flight; saturates at 255.

## Operation
- Tick counter runs 0..TICKS_PER_SAMPLE-1 and wraps. The tick fires in the cycle where count == TICKS_PER_SAMPLE-1 and `enable` = 1.
- Sawtooth base register runs 0..WAVE_PERIOD-1, advances on every tick (including dropped ticks) and wraps to 0.
- Snapshot values per channel c, by mode:
  - sawtooth: (base + c), truncated to SAMPLE_WIDTH.
  - external: `ext_samples` slice for channel c.
  - constant: {SAMPLE_WIDTH{1'b1}} >> 1.
  - channel index: c, zero-extended.
- The snapshot uses the base value from before the increment.
- Frame layout, length 2 + CHANNELS*BYTES:
  - SYNC_BYTE
  - frame_cnt
  - ch0 MSB..LSB, ch1 MSB..LSB, and so on through the last channel.
- frame_cnt is 8 bits, reset 0, and increments after each completed frame; it wraps 255 -> 0.
- Tick while `frame_active` = 1: the frame is not restarted and the snapshot is unchanged. overrun_count increments, holding at 255.
- FSM states:
  - IDLE: on tick, snapshot and go to LOAD.
  - LOAD: if `uart_busy` = 0, pulse data_valid with the current byte and go to ACK; otherwise stay.
  - ACK: one-cycle wait so busy can rise; go to DRAIN.
  - DRAIN: when `uart_busy` = 0, go to LOAD if bytes remain, else go to IDLE and clear frame_active.
- A tick that coincides with the final DRAIN -> IDLE transition counts as an overrun; the next frame starts on the following tick.
- Byte index counter is sized for 2 + 8*3 = 26 bytes. Never index past the frame length.

## Timing
- Reset values: data = 0, data_valid = 0, frame_active = 0, overrun_count = 0. Tick counter, base and frame_cnt all reset to 0; FSM resets to IDLE.
- Tick in cycle t: snapshot and frame_active rise at t+1. The first data_valid (SYNC_BYTE) is at t+2 if `uart_busy` = 0.
- Consecutive data_valid pulses are at least 3 cycles apart (LOAD, ACK, DRAIN), and further apart while busy is held.
- data_valid is never asserted while `uart_busy` = 1.
- Reset asserted mid-frame aborts the frame immediately. All outputs take their reset values asynchronously; no partial frame resumes after release.
- `mode` and `ext_samples` are ignored except in the tick cycle.

## Test plan
- Defaults, `uart_busy` tied 0, mode 0: first frame is A5 00 00 00 00 01; second frame is A5 01 00 01 00 02; first data_valid arrives exactly 2 cycles after the first tick.
- Mode 1 with ext_samples = 32'h1234_ABCD: frame bytes are A5, cnt, AB CD 12 34 (ch0 is the low slice).
- Busy model asserting `uart_busy` for 60 cycles after each accept, TICKS_PER_SAMPLE = 250: each 6-byte frame spans more than 250 cycles. Every other tick is dropped, overrun_count increments once per dropped tick, and data_valid never coincides with busy.
- Hold `uart_busy` = 1 for 300 overruns' worth of ticks: overrun_count saturates at 255 and does not wrap.
- Sawtooth wrap: after 100 ticks base returns to 0. With CHANNELS = 1, SAMPLE_WIDTH = 8 the frame is 3 bytes and shows the sample sequence 0..99, 0.
- Deassert `reset_n` during the 4th byte: data_valid drops immediately, frame_active = 0. After release the first frame starts with A5 00 and base 0.

Source files
------------

// File: rtl/sample_frame_streamer.sv
// Multichannel sample source and UART framer: snapshots one sample per channel on each
// tick and streams SYNC, frame count, then samples MSB-first into a uart_tx byte port.
module sample_frame_streamer #(
  parameter int         CHANNELS         = 2,
  parameter int         SAMPLE_WIDTH     = 16,
  parameter int         TICKS_PER_SAMPLE = 250,
  parameter int         WAVE_PERIOD      = 100,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [1:0]                       mode,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] ext_samples,
  input  logic                             uart_busy,
  output logic [7:0]                       data,
  output logic                             data_valid,
  output logic                             frame_active,
  output logic [7:0]                       overrun_count
);

  localparam int BYTES     = SAMPLE_WIDTH / 8;
  localparam int FRAME_LEN = 2 + CHANNELS * BYTES;
  localparam int PAYLOAD_W = CHANNELS * SAMPLE_WIDTH;
  localparam int TICK_W    = $clog2(TICKS_PER_SAMPLE);
  localparam int BASE_W    = (WAVE_PERIOD > 1) ? $clog2(WAVE_PERIOD) : 1;

  localparam logic [TICK_W-1:0]       TICK_LAST    = TICK_W'(TICKS_PER_SAMPLE - 1);
  localparam logic [BASE_W-1:0]       BASE_LAST    = BASE_W'(WAVE_PERIOD - 1);
  localparam logic [4:0]              END_IDX      = 5'(FRAME_LEN);
  localparam logic [SAMPLE_WIDTH-1:0] CONST_SAMPLE = {SAMPLE_WIDTH{1'b1}} >> 1;

  typedef enum logic [1:0] {IDLE, LOAD, ACK, DRAIN} state_t;

  state_t                state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BASE_W-1:0]     base;
  logic [7:0]            frame_cnt;
  logic [4:0]            byte_idx;
  logic [PAYLOAD_W-1:0]  payload;
  logic [PAYLOAD_W-1:0]  snap_next;
  logic [7:0]            cur_byte;
  logic                  tick;

  assign tick = enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!enable || tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Sawtooth base advances on every tick, including ticks dropped as overruns.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base <= '0;
    end else if (tick) begin
      base <= (base == BASE_LAST) ? '0 : base + BASE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_count <= 8'd0;
    end else if (tick && frame_active && overrun_count != 8'hFF) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end

  // Channel 0 sits at the top of the payload so a left shift emits ch0 MSB first.
  always_comb begin
    snap_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode)
        2'd0:    snap_next[(CHANNELS-1-c)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                   SAMPLE_WIDTH'(32'(base) + 32'(c));
        2'd1:    snap_next[(CHANNELS-1-c)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                   ext_samples[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        2'd2:    snap_next[(CHANNELS-1-c)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = CONST_SAMPLE;
        default: snap_next[(CHANNELS-1-c)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = SAMPLE_WIDTH'(c);
      endcase
    end
  end

  always_comb begin
    cur_byte = payload[PAYLOAD_W-1 -: 8];
    if (byte_idx == 5'd0) begin
      cur_byte = SYNC_BYTE;
    end else if (byte_idx == 5'd1) begin
      cur_byte = frame_cnt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      data         <= 8'd0;
      data_valid   <= 1'b0;
      frame_active <= 1'b0;
      byte_idx     <= 5'd0;
      payload      <= '0;
      frame_cnt    <= 8'd0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            payload      <= snap_next;
            byte_idx     <= 5'd0;
            frame_active <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (!uart_busy) begin
            data       <= cur_byte;
            data_valid <= 1'b1;
            byte_idx   <= byte_idx + 5'd1;
            if (byte_idx >= 5'd2) begin
              payload <= payload << 8;
            end
            state <= ACK;
          end
        end
        ACK: state <= DRAIN;
        DRAIN: begin
          if (!uart_busy) begin
            if (byte_idx == END_IDX) begin
              state        <= IDLE;
              frame_active <= 1'b0;
              frame_cnt    <= frame_cnt + 8'd1;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_frame_streamer.sv
// Scoreboard bench for sample_frame_streamer: a default 2x16-bit instance plus a
// 1x8-bit fast-tick instance for the sawtooth wrap and overrun saturation.
module tb_sample_frame_streamer;

  logic        clock;
  logic        rst0_n, rst1_n;
  logic        enable0, enable1;
  logic [1:0]  mode0, mode1;
  logic [31:0] ext0;
  logic [7:0]  ext1;
  logic        uart_busy0, uart_busy1;
  logic [7:0]  data0, data1;
  logic        data_valid0, data_valid1;
  logic        frame_active0, frame_active1;
  logic [7:0]  overrun0, overrun1;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          first_fa_cyc = -1;
  int          first_dv_cyc = -1;
  int          last_dv_cyc = -1;
  int          busy_viol = 0;
  int          gap_viol = 0;
  int          rel_cyc = 0;
  logic        busy_en = 1'b0;

  logic [7:0]  exp_q[$], rx_q[$], exp1_q[$], rx1_q[$];
  int          model_base = 0;
  logic [7:0]  model_cnt = 8'd0;

  sample_frame_streamer #(
    .CHANNELS(2), .SAMPLE_WIDTH(16), .TICKS_PER_SAMPLE(250), .WAVE_PERIOD(100), .SYNC_BYTE(8'hA5)
  ) dut0 (
    .clock(clock), .reset_n(rst0_n), .enable(enable0), .mode(mode0), .ext_samples(ext0),
    .uart_busy(uart_busy0), .data(data0), .data_valid(data_valid0),
    .frame_active(frame_active0), .overrun_count(overrun0)
  );

  sample_frame_streamer #(
    .CHANNELS(1), .SAMPLE_WIDTH(8), .TICKS_PER_SAMPLE(16), .WAVE_PERIOD(100), .SYNC_BYTE(8'hA5)
  ) dut1 (
    .clock(clock), .reset_n(rst1_n), .enable(enable1), .mode(mode1), .ext_samples(ext1),
    .uart_busy(uart_busy1), .data(data1), .data_valid(data_valid1),
    .frame_active(frame_active1), .overrun_count(overrun1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Output monitor: captures bytes and protocol violations away from the active edge.
  always @(negedge clock) begin
    if (data_valid0) begin
      rx_q.push_back(data0);
      if (uart_busy0) busy_viol++;
      if (last_dv_cyc >= 0 && (cyc - last_dv_cyc) < 3) gap_viol++;
      last_dv_cyc = cyc;
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
    end
    if (frame_active0 && first_fa_cyc < 0) first_fa_cyc = cyc;
    if (data_valid1) rx1_q.push_back(data1);
  end

  // uart_tx stand-in: busy rises the cycle after an accept and stays up for 60 cycles.
  initial begin
    int   cnt;
    logic accept;
    cnt = 0;
    uart_busy0 = 1'b0;
    forever begin
      @(negedge clock);
      accept = data_valid0;
      @(posedge clock);
      #1;
      if (!busy_en) cnt = 0;
      else if (accept) cnt = 60;
      else if (cnt > 0) cnt--;
      uart_busy0 = busy_en && (cnt > 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic skipTick();
    model_base = (model_base + 1) % 100;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] ext);
    logic [15:0] s;
    mode0 = m;
    ext0  = ext;
    exp_q.push_back(8'hA5);
    exp_q.push_back(model_cnt);
    for (int c = 0; c < 2; c++) begin
      case (m)
        2'd0:    s = 16'(model_base + c);
        2'd1:    s = ext[c*16 +: 16];
        2'd2:    s = 16'h7FFF;
        default: s = 16'(c);
      endcase
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
    end
    skipTick();
    model_cnt = model_cnt + 8'd1;
  endtask

  task automatic waitBytes(input int which, input int n, input int budget, input string tag);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      got = (which == 0) ? rx_q.size() : rx1_q.size();
      if (got >= n) break;
      @(negedge clock);
    end
    got = (which == 0) ? rx_q.size() : rx1_q.size();
    checkOutput({tag, "_arrival"}, 32'(got >= n), 32'd1);
  endtask

  task automatic compareBytes(input int which, input int n, input string tag);
    logic [7:0] got, want;
    for (int i = 0; i < n; i++) begin
      got = 'x;
      want = 8'h00;
      if (which == 0) begin
        if (rx_q.size() > 0) got = rx_q.pop_front();
        if (exp_q.size() > 0) want = exp_q.pop_front();
      end else begin
        if (rx1_q.size() > 0) got = rx1_q.pop_front();
        if (exp1_q.size() > 0) want = exp1_q.pop_front();
      end
      checkOutput($sformatf("%s[%0d]", tag, i), 32'(got), 32'(want));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    enable0 = 1'b1; enable1 = 1'b0;
    mode0 = 2'd0; mode1 = 2'd0;
    ext0 = 32'd0; ext1 = 8'd0;
    uart_busy1 = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("reset_data", 32'(data0), 32'h0);
    checkOutput("reset_valid", 32'(data_valid0), 32'h0);
    checkOutput("reset_active", 32'(frame_active0), 32'h0);
    checkOutput("reset_overrun", 32'(overrun0), 32'h0);

    // Sawtooth frames with the UART always ready.
    rel_cyc = cyc;
    rst0_n = 1'b1; rst1_n = 1'b1;
    applyStimulus(2'd0, 32'd0);
    applyStimulus(2'd0, 32'd0);
    waitBytes(0, 12, 800, "saw");
    checkOutput("first_active_cycle", 32'(first_fa_cyc - rel_cyc), 32'd250);
    checkOutput("first_valid_cycle", 32'(first_dv_cyc - rel_cyc), 32'd251);
    compareBytes(0, 12, "saw");

    // Each other pattern for one frame, then sawtooth again to show base kept advancing.
    applyStimulus(2'd1, 32'h1234_ABCD);
    waitBytes(0, 6, 400, "ext");
    compareBytes(0, 6, "ext");
    applyStimulus(2'd2, 32'hFFFF_FFFF);
    waitBytes(0, 6, 400, "const");
    compareBytes(0, 6, "const");
    applyStimulus(2'd3, 32'hFFFF_FFFF);
    waitBytes(0, 6, 400, "chidx");
    compareBytes(0, 6, "chidx");
    applyStimulus(2'd0, 32'd0);
    waitBytes(0, 6, 400, "saw2");
    compareBytes(0, 6, "saw2");
    checkOutput("overrun_none", 32'(overrun0), 32'd0);

    // Slow UART: frames outlast a tick, so every other tick is dropped.
    repeat (30) @(negedge clock);
    busy_en = 1'b1;
    applyStimulus(2'd0, 32'd0); skipTick();
    applyStimulus(2'd0, 32'd0); skipTick();
    applyStimulus(2'd0, 32'd0); skipTick();
    waitBytes(0, 18, 2200, "busy");
    compareBytes(0, 18, "busy");
    checkOutput("overrun_busy", 32'(overrun0), 32'd3);
    checkOutput("valid_while_busy", 32'(busy_viol), 32'd0);
    checkOutput("valid_spacing", 32'(gap_viol), 32'd0);
    enable0 = 1'b0;
    busy_en = 1'b0;
    repeat (100) @(negedge clock);

    // Small instance: 101 three-byte frames walk the sawtooth through its wrap.
    for (int k = 0; k <= 100; k++) begin
      exp1_q.push_back(8'hA5);
      exp1_q.push_back(8'(k));
      exp1_q.push_back(8'(k % 100));
    end
    enable1 = 1'b1;
    waitBytes(1, 303, 2000, "wrap");
    compareBytes(1, 303, "wrap");

    // Stalled UART: one frame hangs, every later tick overruns until the count saturates.
    uart_busy1 = 1'b1;
    repeat (300 * 16 + 20) @(negedge clock);
    checkOutput("overrun_saturate", 32'(overrun1), 32'd255);
    checkOutput("disabled_quiet", 32'(rx_q.size()), 32'd0);
    checkOutput("disabled_inactive", 32'(frame_active0), 32'd0);

    // Reset in the middle of the fourth byte of a frame.
    enable0 = 1'b1;
    mode0 = 2'd0;
    applyStimulus(2'd0, 32'd0);
    waitBytes(0, 3, 400, "pre_reset");
    compareBytes(0, 3, "pre_reset");
    for (int i = 0; i < 20; i++) begin
      if (data_valid0) break;
      @(negedge clock);
    end
    checkOutput("fourth_byte_seen", 32'(data_valid0), 32'd1);
    #1;
    rst0_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(data_valid0), 32'd0);
    checkOutput("abort_active", 32'(frame_active0), 32'd0);
    checkOutput("abort_data", 32'(data0), 32'd0);
    checkOutput("abort_overrun", 32'(overrun0), 32'd0);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (3) @(negedge clock);
    while (rx_q.size() > 0) void'(rx_q.pop_front());
    model_base = 0;
    model_cnt = 8'd0;
    rst0_n = 1'b1;
    applyStimulus(2'd0, 32'd0);
    waitBytes(0, 6, 400, "post_reset");
    compareBytes(0, 6, "post_reset");
    checkOutput("final_valid_while_busy", 32'(busy_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
